// File: rtl/tap_controller_param.sv
// ---------------------------------------------------------------------------
// tap_controller_param
//
// Parametrised IEEE 1149.1-style TAP controller sitting between the board
// JTAG pins and the core I/O boundary. Contains the 16-state TAP FSM, an
// IR_LEN-bit instruction register and three data registers:
//   - BYPASS  (1 bit)
//   - IDCODE  (32 bits, captures IDCODE_VAL)
//   - BSR     (BSR_LEN bits, shift stage plus update latch)
//
// Ports:
//   TCK     in   1        sole clock, everything changes on its rising edge
//   TRST    in   1        synchronous, active-low reset
//   TMS     in   1        test mode select
//   TDI     in   1        serial data in
//   TDO     out  1        serial data out (0 outside ShiftIR/ShiftDR)
//   TDO_EN  out  1        high only in ShiftIR/ShiftDR
//   state   out  4        current TAP state (debug)
//   ir      out  IR_LEN   active instruction
//   bsr_pi  in   BSR_LEN  parallel inputs from pins/core
//   bsr_po  out  BSR_LEN  parallel outputs to pins/core
//   mode    out  1        1 = bsr_po driven from the BSR update latch
// ---------------------------------------------------------------------------
module tap_controller_param #(
  parameter int unsigned IR_LEN     = 4,
  parameter int unsigned BSR_LEN    = 12,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5A6B,
  parameter int unsigned OP_EXTEST  = 0,
  parameter int unsigned OP_SAMPLE  = 1,
  parameter int unsigned OP_INTEST  = 2,
  parameter int unsigned OP_IDCODE  = 3
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               TMS,
  input  logic               TDI,
  output logic               TDO,
  output logic               TDO_EN,
  output logic [3:0]         state,
  output logic [IR_LEN-1:0]  ir,
  input  logic [BSR_LEN-1:0] bsr_pi,
  output logic [BSR_LEN-1:0] bsr_po,
  output logic               mode
);

  // Opcodes resized to the IR width.
  localparam logic [IR_LEN-1:0] OPC_EXTEST = IR_LEN'(OP_EXTEST);
  localparam logic [IR_LEN-1:0] OPC_SAMPLE = IR_LEN'(OP_SAMPLE);
  localparam logic [IR_LEN-1:0] OPC_INTEST = IR_LEN'(OP_INTEST);
  localparam logic [IR_LEN-1:0] OPC_IDCODE = IR_LEN'(OP_IDCODE);

  // Fixed IR capture pattern {0...0,01}: lets a debugger locate IR length.
  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(1);

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    IDLE   = 4'd1,
    SEL_DR = 4'd2,
    SEL_IR = 4'd3,
    CAP_DR = 4'd4,
    CAP_IR = 4'd5,
    SH_DR  = 4'd6,
    SH_IR  = 4'd7,
    EX1_DR = 4'd8,
    EX1_IR = 4'd9,
    PAU_DR = 4'd10,
    PAU_IR = 4'd11,
    EX2_DR = 4'd12,
    EX2_IR = 4'd13,
    UPD_DR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  tap_state_e          state_reg;
  tap_state_e          state_next;

  logic [IR_LEN-1:0]   ir_shift_reg;
  logic [IR_LEN-1:0]   ir_reg;
  logic                mode_reg;

  logic                bypass_reg;
  logic [31:0]         id_shift_reg;
  logic [BSR_LEN-1:0]  bsr_shift_reg;
  logic [BSR_LEN-1:0]  bsr_upd_reg;
  logic [BSR_LEN-1:0]  bsr_shifted;

  logic                sel_id;
  logic                sel_bsr;
  logic                upd_drives_pins;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge TCK) begin
    if (!TRST) begin
      state_reg <= TLR;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic (standard 1149.1 TMS graph)
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TLR:    state_next = TMS ? TLR    : IDLE;
      IDLE:   state_next = TMS ? SEL_DR : IDLE;
      SEL_DR: state_next = TMS ? SEL_IR : CAP_DR;
      SEL_IR: state_next = TMS ? TLR    : CAP_IR;
      CAP_DR: state_next = TMS ? EX1_DR : SH_DR;
      CAP_IR: state_next = TMS ? EX1_IR : SH_IR;
      SH_DR:  state_next = TMS ? EX1_DR : SH_DR;
      SH_IR:  state_next = TMS ? EX1_IR : SH_IR;
      EX1_DR: state_next = TMS ? UPD_DR : PAU_DR;
      EX1_IR: state_next = TMS ? UPD_IR : PAU_IR;
      PAU_DR: state_next = TMS ? EX2_DR : PAU_DR;
      PAU_IR: state_next = TMS ? EX2_IR : PAU_IR;
      EX2_DR: state_next = TMS ? UPD_DR : SH_DR;
      EX2_IR: state_next = TMS ? UPD_IR : SH_IR;
      UPD_DR: state_next = TMS ? SEL_DR : IDLE;
      UPD_IR: state_next = TMS ? SEL_DR : IDLE;
      default: state_next = TLR;
    endcase
  end

  // -------------------------------------------------------------------------
  // DR selection decoded from the active instruction. Anything that is not
  // IDCODE or one of the boundary-scan opcodes (including all-ones) falls
  // back to BYPASS.
  // -------------------------------------------------------------------------
  always_comb begin
    sel_id  = (ir_reg == OPC_IDCODE);
    sel_bsr = (ir_reg == OPC_EXTEST) || (ir_reg == OPC_SAMPLE) ||
              (ir_reg == OPC_INTEST);
  end

  // EXTEST/INTEST hand the pins to the update latch once the IR is updated.
  assign upd_drives_pins = (ir_shift_reg == OPC_EXTEST) ||
                           (ir_shift_reg == OPC_INTEST);

  // -------------------------------------------------------------------------
  // Instruction register and mode. Reloading on *entry* to TLR (rather than
  // while sitting in it) makes ir/mode valid on the same cycle state reads 0.
  // -------------------------------------------------------------------------
  always_ff @(posedge TCK) begin
    if (!TRST) begin
      ir_shift_reg <= '0;
      ir_reg       <= OPC_IDCODE;
      mode_reg     <= 1'b0;
    end else begin
      if (state_next == TLR) begin
        ir_reg   <= OPC_IDCODE;
        mode_reg <= 1'b0;
      end else if (state_reg == UPD_IR) begin
        ir_reg   <= ir_shift_reg;
        mode_reg <= upd_drives_pins;
      end

      case (state_reg)
        CAP_IR:  ir_shift_reg <= IR_CAPTURE;
        SH_IR:   ir_shift_reg <= {TDI, ir_shift_reg[IR_LEN-1:1]};
        default: ir_shift_reg <= ir_shift_reg;
      endcase
    end
  end

  // BSR shift-in value; a single-cell BSR simply takes TDI.
  generate
    if (BSR_LEN == 1) begin : g_bsr_one
      assign bsr_shifted = TDI;
    end else begin : g_bsr_many
      assign bsr_shifted = {TDI, bsr_shift_reg[BSR_LEN-1:1]};
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Data registers. Only the selected register captures/shifts; the others
  // hold, so Pause/Exit2 excursions resume without losing data.
  // -------------------------------------------------------------------------
  always_ff @(posedge TCK) begin
    if (!TRST) begin
      bypass_reg    <= 1'b0;
      id_shift_reg  <= '0;
      bsr_shift_reg <= '0;
      bsr_upd_reg   <= '0;
    end else begin
      case (state_reg)
        CAP_DR: begin
          if (sel_id) begin
            id_shift_reg <= IDCODE_VAL;
          end else if (sel_bsr) begin
            bsr_shift_reg <= bsr_pi;
          end else begin
            bypass_reg <= 1'b0;
          end
        end
        SH_DR: begin
          if (sel_id) begin
            id_shift_reg <= {TDI, id_shift_reg[31:1]};
          end else if (sel_bsr) begin
            bsr_shift_reg <= bsr_shifted;
          end else begin
            bypass_reg <= TDI;
          end
        end
        UPD_DR: begin
          if (sel_bsr) begin
            bsr_upd_reg <= bsr_shift_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: output logic. TDO is combinational from the active shift LSB so the
  // first bit is visible as soon as the Shift state is entered.
  // -------------------------------------------------------------------------
  always_comb begin
    TDO    = 1'b0;
    TDO_EN = 1'b0;
    case (state_reg)
      SH_IR: begin
        TDO_EN = 1'b1;
        TDO    = ir_shift_reg[0];
      end
      SH_DR: begin
        TDO_EN = 1'b1;
        if (sel_id) begin
          TDO = id_shift_reg[0];
        end else if (sel_bsr) begin
          TDO = bsr_shift_reg[0];
        end else begin
          TDO = bypass_reg;
        end
      end
      default: begin
        TDO    = 1'b0;
        TDO_EN = 1'b0;
      end
    endcase
  end

  // Per-cell output mux between the core/pin value and the update latch.
  generate
    for (genvar gi = 0; gi < BSR_LEN; gi++) begin : g_po_mux
      assign bsr_po[gi] = mode_reg ? bsr_upd_reg[gi] : bsr_pi[gi];
    end
  endgenerate

  assign state = state_reg;
  assign ir    = ir_reg;
  assign mode  = mode_reg;

endmodule

// File: tb/tb_tap_controller_param.sv
// ---------------------------------------------------------------------------
// tb_tap_controller_param
//
// Directed bench for tap_controller_param. Stimulus tasks push expected
// TDO bits and state snapshots into queues; a monitor on the falling edge
// pops TDO expectations whenever TDO_EN is high and pops one snapshot per
// cycle when one is pending.
// ---------------------------------------------------------------------------
module tb_tap_controller_param;

  logic        TCK = 1'b0;
  logic        TRST = 1'b0;
  logic        TMS = 1'b0;
  logic        TDI = 1'b0;
  logic        TDO;
  logic        TDO_EN;
  logic [3:0]  state;
  logic [3:0]  ir;
  logic [11:0] bsr_pi = 12'h000;
  logic [11:0] bsr_po;
  logic        mode;

  always #5 TCK = ~TCK;

  tap_controller_param #(
    .IR_LEN(4),
    .BSR_LEN(12),
    .IDCODE_VAL(32'h1234_5A6B),
    .OP_EXTEST(0),
    .OP_SAMPLE(1),
    .OP_INTEST(2),
    .OP_IDCODE(3)
  ) dut (
    .TCK(TCK),
    .TRST(TRST),
    .TMS(TMS),
    .TDI(TDI),
    .TDO(TDO),
    .TDO_EN(TDO_EN),
    .state(state),
    .ir(ir),
    .bsr_pi(bsr_pi),
    .bsr_po(bsr_po),
    .mode(mode)
  );

  typedef struct {
    string name;
    logic  val;
  } tdo_exp_t;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [3:0]  ir_e;
    logic        md;
    logic        chk_po;
    logic [11:0] po;
  } snap_t;

  tdo_exp_t tdo_q[$];
  snap_t    snap_q[$];
  int       tests = 0;
  int       failures = 0;
  tdo_exp_t te;
  snap_t    sn;

  // ------------------------------------------------------------------ monitor
  always @(negedge TCK) begin
    if (TDO_EN === 1'b1) begin
      tests++;
      if (tdo_q.size() == 0) begin
        failures++;
        $display("FAIL tdo_unexpected: TDO_EN got 1 required 0 (state=%0d)", state);
      end else begin
        te = tdo_q.pop_front();
        if (TDO !== te.val) begin
          failures++;
          $display("FAIL %s: TDO got %b required %b", te.name, TDO, te.val);
        end
      end
    end
    if (snap_q.size() > 0) begin
      sn = snap_q.pop_front();
      $display("[TB] snap %s state=%0d ir=%h mode=%b po=%h", sn.name, state, ir, mode, bsr_po);
      tests++;
      if (state !== sn.st) begin
        failures++;
        $display("FAIL %s_state: got %0d required %0d", sn.name, state, sn.st);
      end
      tests++;
      if (ir !== sn.ir_e) begin
        failures++;
        $display("FAIL %s_ir: got %h required %h", sn.name, ir, sn.ir_e);
      end
      tests++;
      if (mode !== sn.md) begin
        failures++;
        $display("FAIL %s_mode: got %b required %b", sn.name, mode, sn.md);
      end
      tests++;
      if ({TDO_EN, TDO} !== 2'b00) begin
        failures++;
        $display("FAIL %s_tdo: got en=%b tdo=%b required en=0 tdo=0", sn.name, TDO_EN, TDO);
      end
      if (sn.chk_po) begin
        tests++;
        if (bsr_po !== sn.po) begin
          failures++;
          $display("FAIL %s_po: got %h required %h", sn.name, bsr_po, sn.po);
        end
      end
    end
  end

  // ------------------------------------------------------------------ tasks
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  task automatic push_tdo(input string name, input logic [31:0] word, input int nbits);
    tdo_exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.name = name;
      e.val  = word[i];
      tdo_q.push_back(e);
    end
  endtask

  task automatic snap(input string name, input logic [3:0] st, input logic [3:0] ire,
                      input logic md, input logic chk, input logic [11:0] po);
    snap_t s;
    s.name   = name;
    s.st     = st;
    s.ir_e   = ire;
    s.md     = md;
    s.chk_po = chk;
    s.po     = po;
    snap_q.push_back(s);
  endtask

  // Idle -> SelDR -> CapDR -> ShDR (capture on the last edge)
  task automatic enter_shdr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Shift bits lo..hi of d; the last edge exits to Exit1.
  task automatic shift_bits(input int lo, input int hi, input logic [31:0] d);
    for (int i = lo; i <= hi; i++) begin
      step(i == hi, d[i]);
    end
  endtask

  // Exit1DR -> UpdDR -> Idle
  task automatic finish_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Full IR scan from Idle back to Idle; checks the capture pattern on TDO.
  task automatic load_ir(input logic [3:0] op, input logic md, input logic chk,
                         input logic [11:0] po, input string name);
    push_tdo({name, "_cap"}, 32'h1, 4);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, op[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    snap(name, 4'd1, op, md, chk, po);
  endtask

  // ------------------------------------------------------------------ watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------ stimulus
  initial begin
    // Reset
    TRST = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    TRST = 1'b1;
    snap("reset", 4'd0, 4'h3, 1'b0, 1'b1, 12'h000);

    // IDCODE readout
    step(1'b0, 1'b0);
    snap("idle", 4'd1, 4'h3, 1'b0, 1'b0, 12'h000);
    push_tdo("idcode", 32'h1234_5A6B, 32);
    enter_shdr();
    shift_bits(0, 31, 32'h0);
    snap("ex1dr", 4'd8, 4'h3, 1'b0, 1'b0, 12'h000);
    finish_dr();

    // BYPASS: TDI 1,0,1,1 -> TDO 0,1,0,1
    load_ir(4'hF, 1'b0, 1'b0, 12'h000, "ir_bypass");
    push_tdo("bypass", 32'b1010, 4);
    enter_shdr();
    shift_bits(0, 3, 32'b1101);
    finish_dr();

    // Undefined opcode behaves as BYPASS: TDI 1,1,0,1 -> TDO 0,1,1,0
    load_ir(4'hA, 1'b0, 1'b0, 12'h000, "ir_undef");
    push_tdo("undef", 32'b0110, 4);
    enter_shdr();
    shift_bits(0, 3, 32'b1011);
    finish_dr();

    // SAMPLE: capture bsr_pi, pins follow bsr_pi
    bsr_pi = 12'hA5C;
    load_ir(4'h1, 1'b0, 1'b1, 12'hA5C, "ir_sample");
    push_tdo("sample", 32'h0000_0A5C, 12);
    enter_shdr();
    shift_bits(0, 11, 32'h0);
    finish_dr();
    snap("sample_po", 4'd1, 4'h1, 1'b0, 1'b1, 12'hA5C);
    step(1'b0, 1'b0);
    bsr_pi = 12'h123;
    snap("sample_follow", 4'd1, 4'h1, 1'b0, 1'b1, 12'h123);
    step(1'b0, 1'b0);

    // EXTEST: latch holds zeros shifted in during SAMPLE
    bsr_pi = 12'h5A5;
    load_ir(4'h0, 1'b1, 1'b1, 12'h000, "ir_extest");
    push_tdo("extest_cap", 32'h0000_05A5, 12);
    enter_shdr();
    shift_bits(0, 11, 32'h0000_03F0);
    finish_dr();
    bsr_pi = 12'hFFF;
    snap("extest_upd", 4'd1, 4'h0, 1'b1, 1'b1, 12'h3F0);
    step(1'b0, 1'b0);

    // Pause/Exit2 excursion mid-shift, resume without recapture
    push_tdo("pause_cap", 32'h0000_0FFF, 12);
    enter_shdr();
    shift_bits(0, 3, 32'h0000_09C3);
    step(1'b0, 1'b0);
    snap("pausedr", 4'd10, 4'h0, 1'b1, 1'b1, 12'h3F0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    snap("exit2dr", 4'd12, 4'h0, 1'b1, 1'b1, 12'h3F0);
    step(1'b0, 1'b0);
    shift_bits(4, 11, 32'h0000_09C3);
    step(1'b1, 1'b0);
    snap("upddr", 4'd14, 4'h0, 1'b1, 1'b1, 12'h3F0);
    step(1'b0, 1'b0);
    snap("resume_upd", 4'd1, 4'h0, 1'b1, 1'b1, 12'h9C3);

    // CapDR with TMS=1: capture still occurs, no shift
    bsr_pi = 12'h6B1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    snap("cap_exit1", 4'd8, 4'h0, 1'b1, 1'b1, 12'h9C3);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    snap("cap_upd", 4'd1, 4'h0, 1'b1, 1'b1, 12'h6B1);

    // TMS=1 x5 from mid-shift reaches TLR, reloads IDCODE, clears mode
    bsr_pi = 12'h0FA;
    push_tdo("tlr_shift", 32'hA, 4);
    enter_shdr();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
    end
    snap("tlr", 4'd0, 4'h3, 1'b0, 1'b1, 12'h0FA);

    // TRST during ShIR aborts the shift
    step(1'b0, 1'b0);
    load_ir(4'h0, 1'b1, 1'b0, 12'h000, "ir_extest2");
    push_tdo("trst_ir", 32'h1, 2);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    TRST = 1'b0;
    step(1'b0, 1'b0);
    TRST = 1'b1;
    snap("trst", 4'd0, 4'h3, 1'b0, 1'b1, 12'h0FA);

    // Reset cleared the update latch
    step(1'b0, 1'b0);
    load_ir(4'h0, 1'b1, 1'b1, 12'h000, "latch_cleared");
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Every expectation must have been consumed
    tests++;
    if (tdo_q.size() != 0) begin
      failures++;
      $display("FAIL tdo_pending: got %0d unconsumed TDO bits required 0", tdo_q.size());
    end
    tests++;
    if (snap_q.size() != 0) begin
      failures++;
      $display("FAIL snap_pending: got %0d unconsumed snapshots required 0", snap_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
